// File: rtl/control_fsm.sv
// Main control FSM for the instruction sequencer.
// Walks FETCH -> DECODE -> EXEC/LOAD/STORE -> FETCH. The instruction is
// latched at the end of DECODE. Every output is decoded from the current
// state and the latched instruction. The one exception is regFileEn in LOAD,
// which follows memReady so the load writes back in its completion cycle.
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opCode,
    input  logic [3:0] opCodeExt,
    input  logic       memReady,
    input  logic [4:0] aluFlags,
    output logic       fetchReq,
    output logic       memWrite,
    output logic       irS,
    output logic       srcRegEn,
    output logic       dstRegEn,
    output logic       immRegEn,
    output logic       signEn,
    output logic       regFileEn,
    output logic       regImmMuxEn,
    output logic       shiftALUMuxEn,
    output logic [1:0] mux4En,
    output logic [1:0] exMemResultEn,
    output logic [1:0] regpcCont,
    output logic [3:0] aluControl,
    output logic [4:0] flags
);

    // State encodings
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;

    // Major opcodes and extension codes
    localparam logic [3:0] OP_REG    = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_SHIFT  = 4'b1000;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STORE = 4'b0100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    // ALU instruction codes. Register ops carry these in ext and immediate
    // ops carry them in opCode.
    localparam logic [3:0] C_ADD = 4'b0101;
    localparam logic [3:0] C_SUB = 4'b1001;
    localparam logic [3:0] C_CMP = 4'b1011;
    localparam logic [3:0] C_AND = 4'b0001;
    localparam logic [3:0] C_OR  = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_MOV = 4'b1101;

    // aluControl encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [3:0] r_op;
    logic [3:0] r_ext;
    logic [4:0] r_flags;

    logic [3:0] w_code;
    logic       w_is_imm;
    logic       w_alu;
    logic       w_mov;
    logic       w_lsh;
    logic       w_lshi;
    logic       w_cmp;
    logic       w_signed;
    logic       w_flag_upd;
    logic [3:0] w_ctrl;

    // Classify the latched instruction; anything unmatched falls through as a NOP
    always_comb begin
        w_is_imm   = (r_op != OP_REG);
        w_code     = w_is_imm ? r_op : r_ext;
        w_alu      = 1'b0;
        w_mov      = 1'b0;
        w_lsh      = 1'b0;
        w_lshi     = 1'b0;
        w_cmp      = 1'b0;
        w_signed   = 1'b0;
        w_flag_upd = 1'b0;
        w_ctrl     = ALU_ADD;
        if (r_op == OP_SHIFT) begin
            if (r_ext == EXT_LSH) begin
                w_lsh = 1'b1;
            end else if (r_ext[3:1] == 3'b000) begin
                w_lshi = 1'b1;
            end
        end else begin
            case (w_code)
                C_ADD: begin
                    w_alu = 1'b1; w_ctrl = ALU_ADD; w_signed = 1'b1; w_flag_upd = 1'b1;
                end
                C_SUB: begin
                    w_alu = 1'b1; w_ctrl = ALU_SUB; w_signed = 1'b1; w_flag_upd = 1'b1;
                end
                C_CMP: begin
                    w_alu = 1'b1; w_ctrl = ALU_CMP; w_signed = 1'b1; w_flag_upd = 1'b1;
                    w_cmp = 1'b1;
                end
                C_AND: begin
                    w_alu = 1'b1; w_ctrl = ALU_AND;
                end
                C_OR: begin
                    w_alu = 1'b1; w_ctrl = ALU_OR;
                end
                C_XOR: begin
                    w_alu = 1'b1; w_ctrl = ALU_XOR;
                end
                C_MOV: begin
                    w_mov = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic; memory ops branch on the live opcode during DECODE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (memReady) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                if (opCode == OP_MEM && opCodeExt == EXT_LOAD) begin
                    w_state_next = S_LOAD;
                end else if (opCode == OP_MEM && opCodeExt == EXT_STORE) begin
                    w_state_next = S_STORE;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
            end
            S_LOAD, S_STORE: begin
                if (memReady) w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // State register; reset wins over any pending transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction latch, loaded on the last DECODE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= 4'b0000;
            r_ext <= 4'b0000;
        end else if (r_state == S_DECODE) begin
            r_op  <= opCode;
            r_ext <= opCodeExt;
        end
    end

    // Flags capture at the end of EXEC for add/sub/compare only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 5'b00000;
        end else if (r_state == S_EXEC && w_flag_upd) begin
            r_flags <= aluFlags;
        end
    end

    assign flags = r_flags;

    // Memory addressing always uses the register path in this control scheme
    assign regpcCont = 2'b00;

    // Output decode from state and latched instruction
    always_comb begin
        fetchReq      = 1'b0;
        memWrite      = 1'b0;
        irS           = 1'b0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        signEn        = 1'b0;
        regFileEn     = 1'b0;
        regImmMuxEn   = 1'b0;
        shiftALUMuxEn = 1'b0;
        mux4En        = 2'b00;
        exMemResultEn = 2'b00;
        aluControl    = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                fetchReq = 1'b1;
                irS      = 1'b1;
            end
            S_DECODE: begin
                srcRegEn = 1'b1;
                dstRegEn = 1'b1;
                immRegEn = 1'b1;
            end
            S_EXEC: begin
                if (w_alu) begin
                    aluControl = w_ctrl;
                    mux4En     = w_is_imm ? 2'b01 : 2'b00;
                    signEn     = w_is_imm & w_signed;
                    regFileEn  = ~w_cmp;
                end else if (w_mov) begin
                    mux4En        = w_is_imm ? 2'b01 : 2'b00;
                    exMemResultEn = 2'b10;
                    regFileEn     = 1'b1;
                end else if (w_lsh) begin
                    shiftALUMuxEn = 1'b1;
                    regFileEn     = 1'b1;
                end else if (w_lshi) begin
                    shiftALUMuxEn = 1'b1;
                    regImmMuxEn   = 1'b1;
                    signEn        = 1'b1;
                    regFileEn     = 1'b1;
                end
            end
            S_LOAD: begin
                exMemResultEn = 2'b01;
                regFileEn     = memReady;
            end
            S_STORE: begin
                memWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm. Each test pushes per-cycle stimulus and the
// expected output vector, built from the instruction tables, into queues.
// The test then replays the queue and compares the DUT outputs at every
// falling edge.
module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] opCode;
    logic [3:0] opCodeExt;
    logic       memReady;
    logic [4:0] aluFlags;
    logic       fetchReq, memWrite, irS, srcRegEn, dstRegEn, immRegEn;
    logic       signEn, regFileEn, regImmMuxEn, shiftALUMuxEn;
    logic [1:0] mux4En, exMemResultEn, regpcCont;
    logic [3:0] aluControl;
    logic [4:0] flags;

    control_fsm dut (
        .clk(clk), .reset(reset), .opCode(opCode), .opCodeExt(opCodeExt),
        .memReady(memReady), .aluFlags(aluFlags),
        .fetchReq(fetchReq), .memWrite(memWrite), .irS(irS),
        .srcRegEn(srcRegEn), .dstRegEn(dstRegEn), .immRegEn(immRegEn),
        .signEn(signEn), .regFileEn(regFileEn), .regImmMuxEn(regImmMuxEn),
        .shiftALUMuxEn(shiftALUMuxEn), .mux4En(mux4En),
        .exMemResultEn(exMemResultEn), .regpcCont(regpcCont),
        .aluControl(aluControl), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       fetchReq, memWrite, irS, srcRegEn, dstRegEn, immRegEn;
        logic       signEn, regFileEn, regImmMuxEn, shiftALUMuxEn;
        logic [1:0] mux4En, exMemResultEn, regpcCont;
        logic [3:0] aluControl;
        logic [4:0] flags;
    } outv_t;

    typedef struct packed {
        logic       rst, mr;
        logic [3:0] op, ext;
        logic [4:0] afl;
    } stim_t;

    localparam int K_NOP = 0, K_ALU = 1, K_MOV = 2, K_LSH = 3, K_LSHI = 4, K_LOAD = 5, K_STORE = 6;

    typedef struct packed {
        logic [2:0] kind;
        logic       imm, sgn, cmp, fupd;
        logic [3:0] ctrl;
    } cls_t;

    outv_t exp_q[$];
    stim_t stim_q[$];
    string name_q[$];
    logic [4:0] m_flags;
    int total = 0;
    int bad = 0;

    // Instruction tables written out directly from the opcode list
    function automatic cls_t classify(input logic [3:0] op, input logic [3:0] ext);
        cls_t c;
        logic [3:0] code;
        c = '0;
        if (op == 4'b0100) begin
            if (ext == 4'b0000) c.kind = 3'(K_LOAD);
            else if (ext == 4'b0100) c.kind = 3'(K_STORE);
        end else if (op == 4'b1000) begin
            if (ext == 4'b0100) c.kind = 3'(K_LSH);
            else if (ext == 4'b0000 || ext == 4'b0001) c.kind = 3'(K_LSHI);
        end else begin
            c.imm = (op != 4'b0000);
            code = c.imm ? op : ext;
            case (code)
                4'b0101: begin c.kind = 3'(K_ALU); c.ctrl = 4'd0; c.sgn = 1'b1; c.fupd = 1'b1; end
                4'b1001: begin c.kind = 3'(K_ALU); c.ctrl = 4'd1; c.sgn = 1'b1; c.fupd = 1'b1; end
                4'b1011: begin c.kind = 3'(K_ALU); c.ctrl = 4'd2; c.sgn = 1'b1; c.fupd = 1'b1; c.cmp = 1'b1; end
                4'b0001: begin c.kind = 3'(K_ALU); c.ctrl = 4'd3; end
                4'b0010: begin c.kind = 3'(K_ALU); c.ctrl = 4'd4; end
                4'b0011: begin c.kind = 3'(K_ALU); c.ctrl = 4'd5; end
                4'b1101: begin c.kind = 3'(K_MOV); end
                default: begin end
            endcase
        end
        return c;
    endfunction

    function automatic outv_t v_base();
        outv_t e;
        e = '0;
        e.flags = m_flags;
        return e;
    endfunction

    function automatic outv_t v_fetch();
        outv_t e;
        e = v_base();
        e.fetchReq = 1'b1;
        e.irS = 1'b1;
        return e;
    endfunction

    function automatic outv_t pack_dut();
        outv_t g;
        g.fetchReq = fetchReq; g.memWrite = memWrite; g.irS = irS;
        g.srcRegEn = srcRegEn; g.dstRegEn = dstRegEn; g.immRegEn = immRegEn;
        g.signEn = signEn; g.regFileEn = regFileEn; g.regImmMuxEn = regImmMuxEn;
        g.shiftALUMuxEn = shiftALUMuxEn; g.mux4En = mux4En;
        g.exMemResultEn = exMemResultEn; g.regpcCont = regpcCont;
        g.aluControl = aluControl; g.flags = flags;
        return g;
    endfunction

    task automatic push_cycle(input logic rst, input logic mr, input logic [3:0] op,
                              input logic [3:0] ext, input logic [4:0] afl,
                              input outv_t e, input string nm);
        stim_t s;
        s.rst = rst; s.mr = mr; s.op = op; s.ext = ext; s.afl = afl;
        stim_q.push_back(s);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Queue one full instruction: optional fetch stalls, decode, then the
    // class-specific execute/memory phase with optional memory stalls.
    task automatic push_instr(input logic [3:0] op, input logic [3:0] ext,
                              input int fwait, input int mwait, input logic [4:0] afl);
        cls_t c;
        outv_t e;
        logic r;
        c = classify(op, ext);
        for (int i = 0; i < fwait; i++) push_cycle(1'b0, 1'b0, op, ext, afl, v_fetch(), "fetch_wait");
        push_cycle(1'b0, 1'b1, op, ext, afl, v_fetch(), "fetch");
        e = v_base();
        e.srcRegEn = 1'b1; e.dstRegEn = 1'b1; e.immRegEn = 1'b1;
        r = 1'($urandom_range(0, 1));
        push_cycle(1'b0, r, op, ext, afl, e, "decode");
        e = v_base();
        if (int'(c.kind) == K_LOAD) begin
            e.exMemResultEn = 2'b01;
            for (int i = 0; i < mwait; i++) push_cycle(1'b0, 1'b0, op, ext, afl, e, "load_wait");
            e.regFileEn = 1'b1;
            push_cycle(1'b0, 1'b1, op, ext, afl, e, "load_done");
        end else if (int'(c.kind) == K_STORE) begin
            e.memWrite = 1'b1;
            for (int i = 0; i < mwait; i++) push_cycle(1'b0, 1'b0, op, ext, afl, e, "store_wait");
            push_cycle(1'b0, 1'b1, op, ext, afl, e, "store_done");
        end else begin
            case (int'(c.kind))
                K_ALU: begin
                    e.aluControl = c.ctrl;
                    e.mux4En = c.imm ? 2'b01 : 2'b00;
                    e.signEn = c.imm & c.sgn;
                    e.regFileEn = ~c.cmp;
                end
                K_MOV: begin
                    e.mux4En = c.imm ? 2'b01 : 2'b00;
                    e.exMemResultEn = 2'b10;
                    e.regFileEn = 1'b1;
                end
                K_LSH: begin
                    e.shiftALUMuxEn = 1'b1;
                    e.regFileEn = 1'b1;
                end
                K_LSHI: begin
                    e.shiftALUMuxEn = 1'b1;
                    e.regImmMuxEn = 1'b1;
                    e.signEn = 1'b1;
                    e.regFileEn = 1'b1;
                end
                default: begin end
            endcase
            r = 1'($urandom_range(0, 1));
            push_cycle(1'b0, r, op, ext, afl, e, "exec");
            if (c.fupd) m_flags = afl;
        end
    endtask

    task automatic test_reset();
        stim_t s; outv_t e, got; string nm;
        m_flags = 5'b0;
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h1F, v_fetch(), "reset_idle");
        push_cycle(1'b1, 1'b1, 4'h0, 4'h0, 5'h1F, v_fetch(), "reset_hold");
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h1F, v_fetch(), "reset_override");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_reset %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_and();
        stim_t s; outv_t e, got; string nm;
        push_instr(4'b0000, 4'b0101, 0, 0, 5'h15);
        push_instr(4'b0000, 4'b0001, 1, 0, 5'h0A);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_add_and %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cmpi();
        stim_t s; outv_t e, got; string nm;
        push_instr(4'b1011, 4'hF, 0, 0, 5'h0C);
        push_instr(4'b0011, 4'hF, 0, 0, 5'h1F);
        push_instr(4'b1101, 4'h3, 0, 0, 5'h13);
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h00, v_fetch(), "idle");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_cmpi %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        stim_t s; outv_t e, got; string nm;
        push_instr(4'b0100, 4'b0000, 0, 3, 5'h07);
        push_instr(4'b0010, 4'h8, 0, 0, 5'h01);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_load %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_reset();
        stim_t s; outv_t e, got; string nm;
        push_instr(4'b0000, 4'b1001, 0, 0, 5'h11);
        push_cycle(1'b0, 1'b1, 4'b0100, 4'b0100, 5'h00, v_fetch(), "st_fetch");
        e = v_base(); e.srcRegEn = 1'b1; e.dstRegEn = 1'b1; e.immRegEn = 1'b1;
        push_cycle(1'b0, 1'b1, 4'b0100, 4'b0100, 5'h00, e, "st_decode");
        e = v_base(); e.memWrite = 1'b1;
        push_cycle(1'b0, 1'b0, 4'b0100, 4'b0100, 5'h00, e, "st_wait1");
        push_cycle(1'b1, 1'b0, 4'b0100, 4'b0100, 5'h00, e, "st_wait2_reset");
        m_flags = 5'b0;
        push_cycle(1'b0, 1'b0, 4'b0100, 4'b0100, 5'h00, v_fetch(), "after_reset");
        push_cycle(1'b0, 1'b0, 4'b0100, 4'b0100, 5'h00, v_fetch(), "after_reset2");
        push_instr(4'b0100, 4'b0100, 0, 2, 5'h1E);
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h00, v_fetch(), "idle");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_store_reset %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_shift_undef();
        stim_t s; outv_t e, got; string nm;
        push_instr(4'b0101, 4'h7, 0, 0, 5'h09);
        push_instr(4'b1000, 4'b0001, 0, 0, 5'h16);
        push_instr(4'b1000, 4'b0100, 0, 0, 5'h16);
        push_instr(4'b1110, 4'b0101, 0, 0, 5'h1F);
        push_instr(4'b0000, 4'b1111, 0, 0, 5'h1F);
        push_instr(4'b0100, 4'b1000, 0, 0, 5'h1F);
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h00, v_fetch(), "idle");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_shift_undef %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Random instruction stream with memReady high in fetch and memory phases
    task automatic test_back_to_back();
        stim_t s; outv_t e, got; string nm;
        logic [7:0] tbl [16];
        logic [7:0] pick;
        tbl = '{8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h50,
                8'h90, 8'hB0, 8'h10, 8'hD0, 8'h40, 8'h44, 8'h84, 8'h80};
        for (int i = 0; i < 24; i++) begin
            pick = tbl[$urandom_range(0, 15)];
            push_instr(pick[7:4], pick[3:0], 0, 0, 5'($urandom_range(0, 31)));
        end
        push_cycle(1'b0, 1'b0, 4'h0, 4'h0, 5'h00, v_fetch(), "idle");
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; memReady = s.mr; opCode = s.op; opCodeExt = s.ext; aluFlags = s.afl;
            @(negedge clk);
            got = pack_dut(); e = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL test_back_to_back %s #%0d: got=%h want=%h", nm, total, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        memReady = 1'b0;
        opCode = 4'h0;
        opCodeExt = 4'h0;
        aluFlags = 5'h0;
        m_flags = 5'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add_and();
        test_cmpi();
        test_load();
        test_store_reset();
        test_shift_undef();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
